irq_scheduler: RTL and testbench

- Central interrupt/exception scheduler for the 5-stage pipelined core.
- Latches exception pulses and samples level interrupts, prioritises them, and issues one PC-redirect request with vector and cause.
- Holds the request through load-use stalls, then tracks kernel entry and exit so only one event is served at a time.
- Mask, global enable, cause and pending state are exposed through a small register port driven by the MEM-stage peripheral decode.

---
 rtl/cpu_pkg.sv | 39 +++
 rtl/irq_prio_enc.sv | 36 +++
 rtl/irq_scheduler.sv | 126 ++++++++++++
 tb/tb_irq_scheduler.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the core's interrupt/exception scheduling logic.
// Holds the scheduler state encoding, register addresses, exception bit positions and cause layout.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ENTER   = 2'd1,
        ST_WAIT_IN = 2'd2,
        ST_SERVE   = 2'd3
    } irq_state_t;

    localparam logic [1:0] REG_MASK  = 2'd0;
    localparam logic [1:0] REG_GIE   = 2'd1;
    localparam logic [1:0] REG_CAUSE = 2'd2;
    localparam logic [1:0] REG_PEND  = 2'd3;

    localparam int NUM_EXC     = 3;
    localparam int EXC_ALU_OVF = 0;
    localparam int EXC_PC_OVF  = 1;
    localparam int EXC_HAZARD  = 2;

    localparam logic [31:0] DEF_VEC_IRQ = 32'h8000_0004;
    localparam logic [31:0] DEF_VEC_EXC = 32'h8000_0008;

    typedef struct packed {
        logic       is_exc;
        logic       rsvd;
        logic [1:0] idx;
    } cause_t;

    function automatic logic [3:0] make_cause(input logic is_exc, input logic [1:0] idx);
        cause_t c;
        c.is_exc = is_exc;
        c.rsvd   = 1'b0;
        c.idx    = idx;
        return c;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority pick of one event: exceptions first (bit2 highest), then lowest-index interrupt.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when the result is consumed.
module irq_prio_enc
    import cpu_pkg::*;
#(
    parameter int NUM_IRQ = 2
) (
    input  logic [NUM_EXC-1:0] exc_pend,
    input  logic [NUM_IRQ-1:0] irq_act,
    output logic               valid,
    output logic               is_exc,
    output logic [1:0]         idx
);

    always_comb begin
        valid  = 1'b0;
        is_exc = 1'b0;
        idx    = 2'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (irq_act[i]) begin
                valid = 1'b1;
                idx   = 2'(i);
            end
        end
        // Exceptions scanned last so they override any interrupt pick.
        for (int i = 0; i < NUM_EXC; i++) begin
            if (exc_pend[i]) begin
                valid  = 1'b1;
                is_exc = 1'b1;
                idx    = 2'(i);
            end
        end
    end

endmodule

// File: rtl/irq_scheduler.sv
// Serves one interrupt/exception at a time: prioritise, redirect the PC, track kernel entry/exit.
// Latency: 2 cycles from an exception pulse to take (latch edge, decide edge); 1 from a level interrupt.
// Backpressure: take/vector/cause hold while stall is high; new events stay pending until IDLE.
module irq_scheduler
    import cpu_pkg::*;
#(
    parameter int          NUM_IRQ       = 2,
    parameter logic [31:0] VEC_IRQ       = DEF_VEC_IRQ,
    parameter logic [31:0] VEC_EXC       = DEF_VEC_EXC,
    parameter int          ENTRY_TIMEOUT = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_src,
    input  logic [NUM_EXC-1:0] exc_src,
    input  logic               kernel_mode,
    input  logic               stall,
    input  logic               reg_wr,
    input  logic [1:0]         reg_addr,
    input  logic [31:0]        reg_wdata,
    output logic [31:0]        reg_rdata,
    output logic               take,
    output logic [31:0]        take_vector,
    output logic [3:0]         cause,
    output logic               timeout_err
);

    localparam int CNT_W = $clog2(ENTRY_TIMEOUT + 1);

    irq_state_t         state;
    logic [CNT_W-1:0]   cnt;
    logic [NUM_IRQ-1:0] mask;
    logic               gie;
    logic [NUM_EXC-1:0] exc_pend;
    logic [NUM_IRQ-1:0] irq_act;
    logic [NUM_EXC-1:0] w1c;
    logic [NUM_EXC-1:0] svc_clr;
    logic               pe_valid;
    logic               pe_is_exc;
    logic [1:0]         pe_idx;
    logic               go;
    logic               unused_wdata;

    assign irq_act      = irq_src & mask;
    assign unused_wdata = ^reg_wdata;

    irq_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_prio (
        .exc_pend (exc_pend),
        .irq_act  (irq_act & {NUM_IRQ{gie}}),
        .valid    (pe_valid),
        .is_exc   (pe_is_exc),
        .idx      (pe_idx)
    );

    assign go      = (state == ST_IDLE) && !kernel_mode && pe_valid;
    assign w1c     = (reg_wr && reg_addr == REG_PEND) ? reg_wdata[NUM_IRQ +: NUM_EXC] : '0;
    assign svc_clr = (go && pe_is_exc) ? (NUM_EXC'(1) << pe_idx) : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_IDLE;
            take        <= 1'b0;
            take_vector <= VEC_IRQ;
            cause       <= 4'd0;
            timeout_err <= 1'b0;
            exc_pend    <= '0;
            mask        <= '1;
            gie         <= 1'b1;
            cnt         <= '0;
        end else begin
            // A fresh pulse outranks any clear of the same bit on this edge.
            exc_pend <= (exc_pend & ~w1c & ~svc_clr) | exc_src;
            if (reg_wr && reg_addr == REG_MASK) mask <= reg_wdata[NUM_IRQ-1:0];
            if (reg_wr && reg_addr == REG_GIE) gie <= reg_wdata[0];
            if (reg_wr && reg_addr == REG_CAUSE && reg_wdata[31]) timeout_err <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (go) begin
                        state       <= ST_ENTER;
                        take        <= 1'b1;
                        take_vector <= pe_is_exc ? VEC_EXC : VEC_IRQ;
                        cause       <= make_cause(pe_is_exc, pe_idx);
                    end
                end
                ST_ENTER: begin
                    if (!stall) begin
                        state <= ST_WAIT_IN;
                        take  <= 1'b0;
                        cnt   <= '0;
                    end
                end
                ST_WAIT_IN: begin
                    if (kernel_mode) begin
                        state <= ST_SERVE;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_W'(ENTRY_TIMEOUT - 1)) begin
                            timeout_err <= 1'b1;
                            state       <= ST_IDLE;
                        end
                    end
                end
                ST_SERVE: begin
                    if (!kernel_mode) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        reg_rdata = '0;
        case (reg_addr)
            REG_MASK:  reg_rdata[NUM_IRQ-1:0] = mask;
            REG_GIE:   reg_rdata[0] = gie;
            REG_CAUSE: begin
                reg_rdata[31]  = timeout_err;
                reg_rdata[3:0] = cause;
            end
            REG_PEND:  reg_rdata[NUM_IRQ+NUM_EXC-1:0] = {exc_pend, irq_act};
            default:   reg_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_irq_scheduler.sv
// Directed bench for irq_scheduler: a phase-level reference model is checked on every negedge,
// with literal expectations at key points of each scenario.
module tb_irq_scheduler;

    localparam int          NUM_IRQ = 2;
    localparam logic [31:0] VEC_IRQ = 32'h8000_0004;
    localparam logic [31:0] VEC_EXC = 32'h8000_0008;
    localparam int          TMO     = 8;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic [NUM_IRQ-1:0] irq_src = '0;
    logic [2:0]         exc_src = '0;
    logic               kernel_mode = 1'b0;
    logic               stall = 1'b0;
    logic               reg_wr = 1'b0;
    logic [1:0]         reg_addr = 2'd0;
    logic [31:0]        reg_wdata = '0;
    logic [31:0]        reg_rdata;
    logic               take;
    logic [31:0]        take_vector;
    logic [3:0]         cause;
    logic               timeout_err;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    irq_scheduler #(.NUM_IRQ(NUM_IRQ), .VEC_IRQ(VEC_IRQ), .VEC_EXC(VEC_EXC), .ENTRY_TIMEOUT(TMO)) dut (
        .clk         (clk),
        .reset       (reset),
        .irq_src     (irq_src),
        .exc_src     (exc_src),
        .kernel_mode (kernel_mode),
        .stall       (stall),
        .reg_wr      (reg_wr),
        .reg_addr    (reg_addr),
        .reg_wdata   (reg_wdata),
        .reg_rdata   (reg_rdata),
        .take        (take),
        .take_vector (take_vector),
        .cause       (cause),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 redirect requested, 2 waiting for kernel, 3 in handler.
    int               m_phase;
    int               m_wait;
    logic             m_take;
    logic [31:0]      m_vec;
    logic [3:0]       m_cause;
    logic             m_err;
    logic [2:0]       m_pend;
    logic [NUM_IRQ-1:0] m_mask;
    logic             m_gie;
    int               w_exc, w_irq;
    logic [2:0]       pend_n;
    logic             err_set;

    function automatic int top_exc(input logic [2:0] p);
        for (int i = 2; i >= 0; i--) if (p[i]) return i;
        return -1;
    endfunction

    function automatic int low_irq(input logic [NUM_IRQ-1:0] a);
        for (int i = 0; i < NUM_IRQ; i++) if (a[i]) return i;
        return -1;
    endfunction

    function automatic logic [31:0] model_rdata(input logic [1:0] a);
        logic [31:0] r;
        r = '0;
        if (a == 2'd0) r = 32'(m_mask);
        else if (a == 2'd1) r = 32'(m_gie);
        else if (a == 2'd2) r = {m_err, 27'd0, m_cause};
        else r = (32'(m_pend) << NUM_IRQ) | 32'(irq_src & m_mask);
        return r;
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            m_phase = 0; m_wait = 0; m_take = 1'b0; m_vec = VEC_IRQ; m_cause = 4'd0;
            m_err = 1'b0; m_pend = '0; m_mask = '1; m_gie = 1'b1;
        end else begin
            w_exc   = top_exc(m_pend);
            w_irq   = m_gie ? low_irq(irq_src & m_mask) : -1;
            pend_n  = m_pend;
            err_set = 1'b0;
            if (reg_wr && reg_addr == 2'd3) pend_n = pend_n & ~reg_wdata[NUM_IRQ +: 3];
            if (m_phase == 0) begin
                if (!kernel_mode && (w_exc >= 0 || w_irq >= 0)) begin
                    m_phase = 1;
                    m_take  = 1'b1;
                    if (w_exc >= 0) begin
                        m_vec   = VEC_EXC;
                        m_cause = 4'(8 + w_exc);
                        pend_n[w_exc] = 1'b0;
                    end else begin
                        m_vec   = VEC_IRQ;
                        m_cause = 4'(w_irq);
                    end
                end
            end else if (m_phase == 1) begin
                if (!stall) begin m_phase = 2; m_take = 1'b0; m_wait = 0; end
            end else if (m_phase == 2) begin
                if (kernel_mode) m_phase = 3;
                else begin
                    m_wait++;
                    if (m_wait == TMO) begin err_set = 1'b1; m_phase = 0; end
                end
            end else begin
                if (!kernel_mode) m_phase = 0;
            end
            m_pend = pend_n | exc_src;
            if (reg_wr && reg_addr == 2'd2 && reg_wdata[31]) m_err = 1'b0;
            if (err_set) m_err = 1'b1;
            if (reg_wr && reg_addr == 2'd0) m_mask = reg_wdata[NUM_IRQ-1:0];
            if (reg_wr && reg_addr == 2'd1) m_gie = reg_wdata[0];
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp_take", 32'(take), 32'(m_take));
            check("cmp_vector", take_vector, m_vec);
            check("cmp_cause", 32'(cause), 32'(m_cause));
            check("cmp_timeout_err", 32'(timeout_err), 32'(m_err));
            check("cmp_rdata", reg_rdata, model_rdata(reg_addr));
        end
    end

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
        end
    endtask

    task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
        reg_wr = 1'b1; reg_addr = a; reg_wdata = d;
        tick();
        reg_wr = 1'b0; reg_wdata = '0;
    endtask

    task automatic reg_read(input string name, input logic [1:0] a, input logic [31:0] exp);
        reg_addr = a;
        #1;
        check(name, reg_rdata, exp);
    endtask

    initial begin
        // 1: reset values, exception pulse to redirect
        tick();
        chk_en = 1'b1;
        tick();
        reset = 1'b1;
        check("rst_take", 32'(take), 32'd0);
        check("rst_vector", take_vector, VEC_IRQ);
        check("rst_cause", 32'(cause), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        reg_read("rst_mask", 2'd0, 32'h3);
        reg_read("rst_gie", 2'd1, 32'h1);
        exc_src = 3'b010;
        tick();
        exc_src = 3'b000;
        check("exc1_take_early", 32'(take), 32'd0);
        tick();
        check("exc1_take", 32'(take), 32'd1);
        check("exc1_vector", take_vector, 32'h8000_0008);
        check("exc1_cause", 32'(cause), 32'h9);
        reg_read("exc1_pend_cleared", 2'd3, 32'h0);
        tick();
        check("exc1_accepted", 32'(take), 32'd0);
        kernel_mode = 1'b1; tick(2);
        kernel_mode = 1'b0; tick(2);

        // 2: interrupt priority, back-to-back service
        irq_src = 2'b11;
        tick();
        check("irq_take", 32'(take), 32'd1);
        check("irq_vector", take_vector, 32'h8000_0004);
        check("irq_cause", 32'(cause), 32'h0);
        tick();
        kernel_mode = 1'b1; tick(2);
        irq_src = 2'b10; kernel_mode = 1'b0;
        tick();
        check("irq_gap", 32'(take), 32'd0);
        tick();
        check("irq2_take", 32'(take), 32'd1);
        check("irq2_cause", 32'(cause), 32'h1);
        irq_src = 2'b00;
        tick();
        kernel_mode = 1'b1; tick();
        kernel_mode = 1'b0; tick(2);

        // 3: stall holds the request; level drop and mask write in ENTER do not cancel it
        irq_src = 2'b01; stall = 1'b1;
        tick();
        check("stall_take0", 32'(take), 32'd1);
        irq_src = 2'b00; reg_wr = 1'b1; reg_addr = 2'd0; reg_wdata = 32'h0;
        tick();
        reg_wr = 1'b0;
        check("stall_take1", 32'(take), 32'd1);
        tick();
        check("stall_take2", 32'(take), 32'd1);
        check("stall_vector", take_vector, VEC_IRQ);
        stall = 1'b0;
        tick();
        check("stall_release", 32'(take), 32'd0);
        kernel_mode = 1'b1;
        reg_write(2'd0, 32'h3);
        kernel_mode = 1'b0; tick(2);

        // 4: MASK and GIE gating
        reg_write(2'd0, 32'h0);
        irq_src = 2'b01;
        tick(3);
        check("masked_no_take", 32'(take), 32'd0);
        reg_write(2'd0, 32'h1);
        tick();
        check("unmask_take", 32'(take), 32'd1);
        check("unmask_cause", 32'(cause), 32'h0);
        irq_src = 2'b00;
        tick();
        kernel_mode = 1'b1; tick();
        kernel_mode = 1'b0; tick(2);
        reg_write(2'd1, 32'h0);
        irq_src = 2'b01;
        tick(2);
        check("gie_off_no_take", 32'(take), 32'd0);
        exc_src = 3'b100;
        tick();
        exc_src = 3'b000;
        tick();
        check("gie_off_exc_take", 32'(take), 32'd1);
        check("gie_off_exc_cause", 32'(cause), 32'hA);
        check("gie_off_exc_vector", take_vector, VEC_EXC);
        tick();
        kernel_mode = 1'b1; tick();
        exc_src = 3'b001;
        reg_write(2'd3, 32'h1 << NUM_IRQ);
        exc_src = 3'b000;
        reg_read("set_beats_w1c", 2'd3, 32'h5);
        reg_write(2'd3, 32'h1 << NUM_IRQ);
        reg_read("w1c_clears", 2'd3, 32'h1);
        irq_src = 2'b00;
        reg_write(2'd1, 32'h1);
        reg_write(2'd0, 32'h3);
        kernel_mode = 1'b0; tick(2);

        // 5: kernel entry timeout
        exc_src = 3'b001;
        tick();
        exc_src = 3'b000;
        tick();
        check("tmo_take", 32'(take), 32'd1);
        tick();
        tick(TMO - 1);
        check("tmo_not_yet", 32'(timeout_err), 32'd0);
        tick();
        check("tmo_err", 32'(timeout_err), 32'd1);
        reg_read("tmo_reg", 2'd2, 32'h8000_0008);
        tick();
        check("tmo_idle_no_take", 32'(take), 32'd0);
        reg_write(2'd2, 32'h8000_0000);
        reg_read("tmo_cleared", 2'd2, 32'h0000_0008);

        // 6: reset during ENTER
        irq_src = 2'b01;
        tick();
        check("rst_enter_take", 32'(take), 32'd1);
        stall = 1'b1; exc_src = 3'b011;
        tick();
        exc_src = 3'b000;
        reset = 1'b0;
        tick();
        check("rst_mid_take", 32'(take), 32'd0);
        reg_read("rst_mid_mask", 2'd0, 32'h3);
        reg_read("rst_mid_gie", 2'd1, 32'h1);
        reg_read("rst_mid_pend", 2'd3, 32'h1);
        reset = 1'b1; irq_src = 2'b00; stall = 1'b0;
        tick(2);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
